lcd_bus_reader: RTL and testbench

Read-side engine for the HD44780-style character LCD bus (LCD_E/LCD_RS/LCD_RW/8-bit data). It executes single read cycles on request: either a status read (busy flag + address counter, RS=0) or a DDRAM/CGRAM data read (RS=1). An optional busy-poll mode repeats status reads until BF=0 or a limit is reached. It sits beside the LCD write controller, and an external bus mux gives it the pins; it never drives the data bus.

---
 rtl/lcd_bus_reader.sv | 168 ++++++++++++++++
 tb/tb_lcd_bus_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_reader.sv
// Read-side engine for an HD44780-style LCD bus: single status/data reads with optional
// busy-flag polling. Never drives the data bus; LCD_RW is held at 1.
module lcd_bus_reader #(
  parameter int unsigned CLK_DIV      = 5,
  parameter int unsigned SETUP_TICKS  = 1,
  parameter int unsigned E_HIGH_TICKS = 2,
  parameter int unsigned HOLD_TICKS   = 1,
  parameter int unsigned POLL_LIMIT   = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ,
  input  logic       REQ_RS,
  input  logic       REQ_POLL,
  output logic       BUSY,
  output logic       RD_VALID,
  output logic [7:0] RD_DATA,
  output logic       BF,
  output logic [6:0] AC,
  output logic       TIMEOUT,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  input  logic [7:0] LCD_DATA_IN
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CW = $clog2(POLL_LIMIT + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StEHigh = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StCheck = 3'd4;

  logic [2:0]    state_q;
  logic [PW-1:0] pre_q;
  logic [7:0]    tick_cnt_q;
  logic [7:0]    tick_lim;
  logic          tick;
  logic          last_tick;
  logic          rs_q;
  logic          poll_q;
  logic [CW-1:0] poll_cnt_q;
  logic [CW-1:0] poll_nxt;
  logic [7:0]    sample_q;
  logic [7:0]    rd_data_q;
  logic          bf_q;
  logic [6:0]    ac_q;
  logic          rd_valid_q;
  logic          timeout_q;
  logic          lcd_e_q;
  logic          lcd_rs_q;

  assign tick     = (pre_q == PW'(CLK_DIV - 1));
  assign poll_nxt = poll_cnt_q + 1'b1;

  always_comb begin
    tick_lim = '0;
    case (state_q)
      StSetup: tick_lim = 8'(SETUP_TICKS - 1);
      StEHigh: tick_lim = 8'(E_HIGH_TICKS - 1);
      StHold:  tick_lim = 8'(HOLD_TICKS - 1);
      default: tick_lim = '0;
    endcase
  end

  assign last_tick = tick && (tick_cnt_q == tick_lim);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      pre_q      <= '0;
      tick_cnt_q <= '0;
      rs_q       <= 1'b1;
      poll_q     <= 1'b0;
      poll_cnt_q <= '0;
      sample_q   <= '0;
      rd_data_q  <= '0;
      bf_q       <= 1'b1;
      ac_q       <= '0;
      rd_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      pre_q      <= tick ? '0 : pre_q + 1'b1;
      if (last_tick) begin
        tick_cnt_q <= '0;
      end else if (tick) begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          pre_q      <= '0;
          tick_cnt_q <= '0;
          lcd_e_q    <= 1'b0;
          if (REQ) begin
            rs_q       <= REQ_RS;
            poll_q     <= REQ_POLL & ~REQ_RS;
            poll_cnt_q <= '0;
            lcd_rs_q   <= REQ_RS;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          if (last_tick) begin
            lcd_e_q <= 1'b1;
            state_q <= StEHigh;
          end
        end
        StEHigh: begin
          if (last_tick) begin
            sample_q <= LCD_DATA_IN;
            lcd_e_q  <= 1'b0;
            state_q  <= StHold;
          end
        end
        StHold: begin
          // Results are registered on entry so they are visible during the CHECK cycle.
          if (last_tick) begin
            state_q <= StCheck;
            if (!rs_q) begin
              bf_q <= sample_q[7];
              ac_q <= sample_q[6:0];
            end
            if (!poll_q || !sample_q[7]) begin
              rd_data_q  <= sample_q;
              rd_valid_q <= 1'b1;
            end else begin
              poll_cnt_q <= poll_nxt;
              if (poll_nxt == CW'(POLL_LIMIT)) begin
                timeout_q <= 1'b1;
              end
            end
          end
        end
        StCheck: begin
          if (rd_valid_q || timeout_q) begin
            state_q <= StIdle;
          end else begin
            pre_q      <= '0;
            tick_cnt_q <= '0;
            state_q    <= StSetup;
          end
        end
        default: begin
          lcd_e_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign BUSY     = (state_q != StIdle);
  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign BF       = bf_q;
  assign AC       = ac_q;
  assign TIMEOUT  = timeout_q;
  assign LCD_E    = lcd_e_q;
  assign LCD_RS   = lcd_rs_q;
  assign LCD_RW   = 1'b1;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader: table vectors, hand-written corner sequences and
// randomized reads checked against a per-request outcome model.
module tb_lcd_bus_reader;

  localparam int CLK_DIV = 5;
  localparam int SETUP_T = 1;
  localparam int EHIGH_T = 2;
  localparam int HOLD_T  = 1;
  localparam int LIMIT   = 4;
  localparam int LAT     = CLK_DIV * (SETUP_T + EHIGH_T + HOLD_T);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       req_rs = 1'b0;
  logic       req_poll = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, rd_valid, bf, timeout, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] rd_data;
  logic [6:0] ac;

  lcd_bus_reader #(
    .CLK_DIV     (CLK_DIV),
    .SETUP_TICKS (SETUP_T),
    .E_HIGH_TICKS(EHIGH_T),
    .HOLD_TICKS  (HOLD_T),
    .POLL_LIMIT  (LIMIT)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .REQ        (req),
    .REQ_RS     (req_rs),
    .REQ_POLL   (req_poll),
    .BUSY       (busy),
    .RD_VALID   (rd_valid),
    .RD_DATA    (rd_data),
    .BF         (bf),
    .AC         (ac),
    .TIMEOUT    (timeout),
    .LCD_E      (lcd_e),
    .LCD_RS     (lcd_rs),
    .LCD_RW     (lcd_rw),
    .LCD_DATA_IN(din)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Byte k of dq is presented on the k-th E pulse of a request; the last byte repeats.
  logic [7:0][7:0] dq;
  int              dix = 0;
  always @(posedge lcd_e) begin
    din = dq[dix];
    if (dix < 7) dix = dix + 1;
  end

  // Expected architectural state carried between requests.
  logic [7:0] m_data = 8'h00;
  logic       m_bf = 1'b1;
  logic [6:0] m_ac = 7'h00;

  typedef struct {
    logic            rs;
    logic            poll;
    logic [7:0][7:0] b;
    int              pulses;
    int              nval;
    int              nto;
    int              last;
    logic [7:0]      data;
    logic            bf;
    logic [6:0]      ac;
  } vec_t;

  vec_t tv[5];

  function automatic logic [7:0][7:0] mk(input logic [7:0] d0, d1, d2, d3);
    return {d3, d3, d3, d3, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome of one request derived from the read rules: each E pulse samples one byte.
  task automatic model(input logic rs, poll, input logic [7:0][7:0] b,
                       output int pulses, nval, nto, last);
    pulses = 0; nval = 0; nto = 0; last = -1;
    if (rs || !poll) begin
      pulses = 1; nval = 1; last = LAT; m_data = b[0];
      if (!rs) begin
        m_bf = b[0][7];
        m_ac = b[0][6:0];
      end
    end else begin
      for (int i = 0; i < LIMIT; i++) begin
        m_bf = b[i][7];
        m_ac = b[i][6:0];
        pulses = i + 1;
        last = (LAT + 1) * i + LAT;
        if (!b[i][7]) begin
          nval = 1;
          m_data = b[i];
          break;
        end
        if (i == LIMIT - 1) nto = 1;
      end
    end
  endtask

  task automatic run_read(input logic rs, poll, input logic [7:0][7:0] b, input bit mid,
                          output int pulses, e_hi, nval, nto, last, busy_low, rs_bad);
    logic prev_e;
    pulses = 0; e_hi = 0; nval = 0; nto = 0; last = -1; busy_low = -1; rs_bad = 0;
    prev_e = 1'b0;
    dq = b;
    dix = 0;
    @(negedge clk);
    req = 1'b1; req_rs = rs; req_poll = poll;
    @(posedge clk);
    for (int rel = 0; rel < 2000; rel++) begin
      @(negedge clk);
      req = mid && (rel == 8 || rel == LAT);
      if (lcd_e && !prev_e) pulses++;
      if (lcd_e) e_hi++;
      prev_e = lcd_e;
      if (rd_valid) begin nval++; last = rel; end
      if (timeout) begin nto++; last = rel; end
      if (busy && (lcd_rs !== rs || lcd_rw !== 1'b1)) rs_bad++;
      if (!busy) begin busy_low = rel; break; end
    end
    req = 1'b0;
    if (mid) begin
      repeat (3) begin
        @(negedge clk);
        chk("mid_req_ignored", {31'd0, busy}, 32'd0);
      end
    end
  endtask

  task automatic exec(input string tag, input logic rs, poll, input logic [7:0][7:0] b,
                      input bit mid, input int e_pulses, e_val, e_to, e_last,
                      input logic [7:0] e_data, input logic e_bf, input logic [6:0] e_ac);
    int pulses, e_hi, nval, nto, last, busy_low, rs_bad;
    run_read(rs, poll, b, mid, pulses, e_hi, nval, nto, last, busy_low, rs_bad);
    chk({tag, ".e_pulses"}, pulses, e_pulses);
    chk({tag, ".e_high_clks"}, e_hi, e_pulses * CLK_DIV * EHIGH_T);
    chk({tag, ".rd_valid_cnt"}, nval, e_val);
    chk({tag, ".timeout_cnt"}, nto, e_to);
    chk({tag, ".done_cycle"}, last, e_last);
    chk({tag, ".busy_low_cycle"}, busy_low, e_last + 1);
    chk({tag, ".rs_rw_stable"}, rs_bad, 0);
    chk({tag, ".rd_data"}, {24'd0, rd_data}, {24'd0, e_data});
    chk({tag, ".bf"}, {31'd0, bf}, {31'd0, e_bf});
    chk({tag, ".ac"}, {25'd0, ac}, {25'd0, e_ac});
  endtask

  initial begin
    int v1, v2, nv, b21, b22, pulses, nval, nto, last;
    logic [7:0] d2;
    logic [7:0][7:0] rb;
    logic rrs, rpoll;

    tv[0] = '{1'b1, 1'b0, mk(8'h4B, 8'h4B, 8'h4B, 8'h4B), 1, 1, 0, 20, 8'h4B, 1'b1, 7'h00};
    tv[1] = '{1'b0, 1'b0, mk(8'hC5, 8'hC5, 8'hC5, 8'hC5), 1, 1, 0, 20, 8'hC5, 1'b1, 7'h45};
    tv[2] = '{1'b0, 1'b1, mk(8'h80, 8'h80, 8'h80, 8'h12), 4, 1, 0, 83, 8'h12, 1'b0, 7'h12};
    tv[3] = '{1'b0, 1'b1, mk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 4, 0, 1, 83, 8'h12, 1'b1, 7'h7F};
    tv[4] = '{1'b1, 1'b1, mk(8'h80, 8'h80, 8'h80, 8'h80), 1, 1, 0, 20, 8'h80, 1'b1, 7'h7F};

    repeat (3) @(negedge clk);
    chk("reset.lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("reset.lcd_rs", {31'd0, lcd_rs}, 32'd1);
    chk("reset.lcd_rw", {31'd0, lcd_rw}, 32'd1);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset.rd_data", {24'd0, rd_data}, 32'd0);
    chk("reset.bf", {31'd0, bf}, 32'd1);
    chk("reset.ac", {25'd0, ac}, 32'd0);
    chk("reset.timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      exec($sformatf("vec%0d", k), tv[k].rs, tv[k].poll, tv[k].b, 1'b0, tv[k].pulses,
           tv[k].nval, tv[k].nto, tv[k].last, tv[k].data, tv[k].bf, tv[k].ac);
    end

    // REQ pulses mid-read and during CHECK must be dropped.
    exec("mid_req", 1'b1, 1'b0, mk(8'h5A, 8'h5A, 8'h5A, 8'h5A), 1'b1, 1, 1, 0, 20,
         8'h5A, 1'b1, 7'h7F);

    // REQ held high: second read accepted on the first IDLE cycle after CHECK.
    dq = mk(8'hA1, 8'hA2, 8'hA3, 8'hA3);
    dix = 0;
    nv = 0; v1 = -1; v2 = -1; b21 = -1; b22 = -1; d2 = 8'h00;
    @(negedge clk);
    req = 1'b1; req_rs = 1'b1; req_poll = 1'b0;
    @(posedge clk);
    for (int rel = 0; rel < 60; rel++) begin
      @(negedge clk);
      if (rel == 25) req = 1'b0;
      if (rel == LAT + 1) b21 = int'(busy);
      if (rel == LAT + 2) b22 = int'(busy);
      if (rd_valid) begin
        nv++;
        if (nv == 1) v1 = rel;
        else begin v2 = rel; d2 = rd_data; end
      end
    end
    chk("held.valid_cnt", nv, 2);
    chk("held.first_valid", v1, LAT);
    chk("held.second_valid", v2, 2 * LAT + 2);
    chk("held.second_data", {24'd0, d2}, 32'hA2);
    chk("held.busy_after_check", b21, 0);
    chk("held.busy_restart", b22, 1);

    // Reset during E_HIGH abandons the read.
    dq = mk(8'h77, 8'h77, 8'h77, 8'h77);
    dix = 0;
    @(negedge clk);
    req = 1'b1; req_rs = 1'b1; req_poll = 1'b0;
    @(posedge clk);
    for (int rel = 0; rel < 8; rel++) begin
      @(negedge clk);
      req = 1'b0;
    end
    chk("rst_mid.e_before", {31'd0, lcd_e}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_mid.bf", {31'd0, bf}, 32'd1);
    chk("rst_mid.ac", {25'd0, ac}, 32'd0);
    chk("rst_mid.lcd_rs", {31'd0, lcd_rs}, 32'd1);
    rst = 1'b0;
    nv = 0;
    for (int rel = 0; rel < 30; rel++) begin
      @(negedge clk);
      if (rd_valid || timeout) nv++;
    end
    chk("rst_mid.no_pulses", nv, 0);
    exec("after_rst", 1'b1, 1'b0, mk(8'h31, 8'h31, 8'h31, 8'h31), 1'b0, 1, 1, 0, 20,
         8'h31, 1'b1, 7'h00);

    m_data = 8'h31; m_bf = 1'b1; m_ac = 7'h00;
    for (int r = 0; r < 25; r++) begin
      rrs = 1'($urandom_range(0, 1));
      rpoll = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        rb[i] = 8'($urandom);
        rb[i][7] = ($urandom_range(0, 2) != 0);
      end
      model(rrs, rpoll, rb, pulses, nval, nto, last);
      exec($sformatf("rand%0d", r), rrs, rpoll, rb, 1'b0, pulses, nval, nto, last,
           m_data, m_bf, m_ac);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
